// File: rtl/imem_arbiter.sv
// Single-port instruction-RAM arbiter between CPU fetch (read-only) and a loader/debug port.
// Optional fetch starvation guard enabled by defining IMEM_ARB_STARVE_EN.
module imem_arbiter #(
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned CW       = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  output logic        f_gnt,
  output logic        f_rvalid,
  output logic [31:0] f_rdata,
  input  logic        l_req,
  input  logic        l_we,
  input  logic        l_lock,
  input  logic [31:0] l_addr,
  input  logic [31:0] l_wdata,
  output logic        l_gnt,
  output logic        l_rvalid,
  output logic [31:0] l_rdata,
  output logic        m_en,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  output logic        locked
);

  typedef enum logic {
    FREE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e state_q, state_d;
  logic   arb_locked;
  logic   fetch_wins;
  logic   rd_pend_q, rd_pend_d;
  logic   rd_fetch_q, rd_fetch_d;

  if ((2 ** CW) <= MAX_WAIT) begin : g_cw_check
    $error("imem_arbiter: CW too narrow to hold MAX_WAIT");
  end

  // Lock release is seen combinationally: the cycle l_lock drops already arbitrates as FREE.
  assign arb_locked = (state_q == LOCKED) && l_lock;

  always_comb begin
    state_d = state_q;
    f_gnt   = 1'b0;
    l_gnt   = 1'b0;
    if (reset_n) begin
      if (arb_locked) begin
        l_gnt = l_req;
      end else if (f_req && l_req) begin
        f_gnt = fetch_wins;
        l_gnt = !fetch_wins;
      end else begin
        f_gnt = f_req;
        l_gnt = l_req;
      end
    end
    case (state_q)
      FREE:    if (l_gnt && l_lock) state_d = LOCKED;
      LOCKED:  if (!l_lock) state_d = FREE;
      default: state_d = FREE;
    endcase
  end

  assign m_en    = f_gnt | l_gnt;
  assign m_we    = l_gnt & l_we;
  assign m_addr  = f_gnt ? (f_addr & 32'hFFFF_FFFC) :
                   l_gnt ? (l_addr & 32'hFFFF_FFFC) : '0;
  assign m_wdata = l_gnt ? l_wdata : '0;

  assign rd_pend_d  = m_en & ~m_we;
  assign rd_fetch_d = f_gnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= FREE;
      rd_pend_q  <= 1'b0;
      rd_fetch_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_pend_q  <= rd_pend_d;
      rd_fetch_q <= rd_fetch_d;
    end
  end

  assign f_rvalid = rd_pend_q & rd_fetch_q;
  assign l_rvalid = rd_pend_q & ~rd_fetch_q;
  assign f_rdata  = m_rdata;
  assign l_rdata  = m_rdata;
  assign locked   = (state_q == LOCKED);

`ifdef IMEM_ARB_STARVE_EN
  logic [CW-1:0] wait_q, wait_d;

  assign fetch_wins = (wait_q == CW'(MAX_WAIT));

  // Counter is frozen while a lock is in force.
  always_comb begin
    wait_d = wait_q;
    if (!arb_locked) begin
      if (f_gnt) begin
        wait_d = '0;
      end else if (f_req && !fetch_wins) begin
        wait_d = wait_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end
`else
  assign fetch_wins = 1'b0;
`endif

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Single-port instruction-memory arbiter for the single-cycle ARM core. It shares one synchronous instruction RAM between the CPU fetch port (read-only) and a program-loader/debug port (read/write). It grants at most one access per cycle, tracks which requester owns the in-flight read, and returns data with a one-cycle latency. The block replaces the hard-wired ROM path, so that programs can be loaded at run time while fetch is stalled.

## Interface
Parameters:
- MAX_WAIT, 4: number of consecutive denied fetch cycles before fetch is forced to win a conflict (used only with the starvation guard).
- CW, 3: width of the starvation counter; must satisfy 2^CW > MAX_WAIT.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- f_req  in  1  fetch read request.
- f_addr  in  32  fetch byte address.
- f_gnt  out  1  fetch granted this cycle (combinational).
- f_rvalid  out  1  fetch read data valid (registered).
- f_rdata  out  32  fetch read data.
- l_req  in  1  loader request.
- l_we  in  1  loader write (1) / read (0).
- l_lock  in  1  loader requests exclusive ownership.
- l_addr  in  32  loader byte address.
- l_wdata  in  32  loader write data.
- l_gnt  out  1  loader granted this cycle (combinational).
- l_rvalid  out  1  loader read data valid (registered).
- l_rdata  out  32  loader read data.
- m_en  out  1  memory access enable.
- m_we  out  1  memory write enable.
- m_addr  out  32  memory byte address, with bits [1:0] forced to 0.
- m_wdata  out  32  memory write data.
- m_rdata  in  32  memory read data, valid the cycle after m_en with m_we=0.
- locked  out  1  arbiter is in the LOCKED state.

## Operation
- **States:** FREE and LOCKED.
- **FREE:**
  - A lone request is granted.
  - On a conflict (f_req and l_req both high), the loader wins, except as described under Configuration.
- **FREE→LOCKED:** taken when l_gnt=1 and l_lock=1 in the same cycle.
- **LOCKED:**
  - f_gnt is held at 0 regardless of f_req.
  - l_req is granted every cycle it is asserted.
- **LOCKED→FREE:** taken on the first cycle l_lock=0. That cycle already arbitrates as FREE, so the transition is combinationally visible.
- **Memory mux:**
  - m_en = f_gnt | l_gnt.
  - m_we = l_gnt & l_we.
  - m_addr and m_wdata come from the granted requester.
  - When nothing is granted, m_addr and m_wdata are 0.
- **Read ownership:**
  - A registered owner flag records whether the granted read (m_en & ~m_we) belongs to fetch or loader.
  - Next cycle, exactly one of f_rvalid / l_rvalid pulses high.
  - f_rdata and l_rdata both mirror m_rdata. They are meaningful only while the matching rvalid is high.
- **Writes:** produce no rvalid.
- **Requester contract:** a requester must hold its request and address stable until it sees gnt. Back-to-back grants are allowed every cycle.

## Timing
- Grant is combinational, in the same cycle as the request. Read latency is exactly 1 cycle from gnt to rvalid.
- Throughput is one access per cycle.
- **Reset values:**
  - f_rvalid=0, l_rvalid=0, locked=0.
  - State=FREE, starvation counter=0, owner cleared.
  - While reset_n=0, f_gnt, l_gnt, m_en and m_we are all 0.
- **Reset mid-read:** an outstanding read is dropped and no rvalid is issued after reset release.
- **Simultaneous lock release and fetch request:** fetch is granted in the same cycle l_lock falls if l_req=0.
- **Address alignment:** address bits [1:0] are ignored, so unaligned fetch addresses return the enclosing word.

## Configuration
- Macro: IMEM_ARB_STARVE_EN.
- **Defined:**
  - In FREE, a counter increments on each cycle f_req=1 and f_gnt=0, saturating at MAX_WAIT.
  - It resets to 0 on any fetch grant.
  - When the count equals MAX_WAIT, fetch wins the next conflict.
  - The counter is frozen in LOCKED, because a lock overrides the guard.
- **Undefined:**
  - The counter logic is absent.
  - The loader always wins conflicts in FREE.

## Test plan
- **Lone fetch read:** f_req=1, f_addr=0x0000_0008 → f_gnt=1, m_addr=0x8, m_we=0; next cycle f_rvalid=1 and f_rdata equals the memory word at 0x8; l_rvalid=0.
- **Loader write then fetch:** l_req=1, l_we=1, l_addr=0x4, l_wdata=0xE082_2004, then f_req reading 0x4 → m_we=1 in cycle 0; fetch rvalid in cycle 2 with data 0xE082_2004.
- **Conflict:** f_req=l_req=1 for 6 cycles, l_we=0.
  - Without the macro: l_gnt=1 on all 6 cycles.
  - With the macro and MAX_WAIT=4: f_gnt=1 on cycle 5 and the counter returns to 0.
- **Lock:** l_lock=1 with l_req granted → locked=1 the next cycle. With f_req=1 held for 5 cycles, f_gnt stays 0. When l_lock drops with l_req=0, f_gnt=1 in that cycle and locked=0 the next.
- **Reset mid-read:** fetch granted, then reset_n=0 before the rising edge → after release f_rvalid=0, locked=0, and the counter is 0.
